mbus_memory_ctrl: RTL and testbench

MBUS_MEMORY_CTRL -- requirements
Module: mbus_memory_ctrl

---
 rtl/mbus_memory_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mbus_memory_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mbus_memory_ctrl.sv
// mbus_memory_ctrl: quadword memory controller on the MBOX side.
// Accepts one read or write request at a time, acknowledges it after
// ACK_DLY cycles, then moves up to four words of a quadword in wrap order
// starting at the requested word. Reads return one word every RD_DLY
// cycles; writes consume one word per outValidA strobe.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   memReset           synchronous soft reset (memory contents kept)
//   startA/rdRq/wrRq   request strobe and operation select
//   rq[0:3]            word-select mask within the quadword
//   adr[14:35], adrPar word address and its odd parity
//   dOut[0:35], parOut write data and its odd parity
//   outValidA          write data valid
//   acknA              one-cycle request acknowledge
//   inValidA           one-cycle read data valid
//   dIn[0:35], parIn   read data and its odd parity (held between words)
//   error              sticky error flag
//   busy               controller not idle
//   dbg_state_o        current FSM state (IDLE=0 ACKW=1 RDW=2 WRW=3 DONE=4)
//
// Handshake: a request is taken only in IDLE on a cycle with startA=1;
// write data is taken only in WRW on a cycle with outValidA=1. There is no
// backpressure on the MBOX side, and strobes outside those states are dropped.
module mbus_memory_ctrl #(
  parameter int DEPTH_LOG2    = 16,
  parameter int ACK_DLY       = 2,
  parameter int RD_DLY        = 3,
  parameter bit CHECK_ADR_PAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memReset,
  input  logic        startA,
  input  logic        rdRq,
  input  logic        wrRq,
  input  logic [0:3]  rq,
  input  logic [14:35] adr,
  input  logic        adrPar,
  input  logic [0:35] dOut,
  input  logic        parOut,
  input  logic        outValidA,
  output logic        acknA,
  output logic        inValidA,
  output logic [0:35] dIn,
  output logic        parIn,
  output logic        error,
  output logic        busy,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACKW = 3'd1,
    S_RDW  = 3'd2,
    S_WRW  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] ACK_LAST = 4'(ACK_DLY - 1);
  localparam logic [3:0] RD_LAST  = 4'(RD_DLY - 1);

  logic [35:0] mem [2**DEPTH_LOG2];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:33] adr_q, adr_d;
  logic [0:3]  rem_q, rem_d;    // selected words not yet transferred
  logic [1:0]  ptr_q, ptr_d;
  logic        wr_q, wr_d;
  logic        ack_q, ack_d;
  logic        inv_q, inv_d;
  logic [0:35] din_q, din_d;
  logic        par_q, par_d;
  logic        err_q, err_d;

  logic        mem_we;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [1:0]  cur_pos;
  logic [1:0]  scan_p;
  logic        found;
  logic        last_word;
  logic        adr_ok;

  // First still-pending position at or after the pointer (mod 4). Skipped
  // positions therefore cost no cycles.
  always_comb begin
    cur_pos = ptr_q;
    scan_p  = '0;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      scan_p = ptr_q + 2'(i);
      if (!found && rem_q[scan_p]) begin
        cur_pos = scan_p;
        found   = 1'b1;
      end
    end
  end

  assign last_word = ($countones(rem_q) == 1);
  // Upper address bits beyond the backing store simply alias.
  assign mem_idx   = DEPTH_LOG2'({adr_q, cur_pos});
  assign adr_ok    = !CHECK_ADR_PAR || (^{adr, adrPar});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    wr_d    = wr_q;
    ack_d   = 1'b0;
    inv_d   = 1'b0;
    din_d   = din_q;
    par_d   = par_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    if (memReset) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (startA) begin
            if ((rdRq != wrRq) && adr_ok) begin
              adr_d   = adr[14:33];
              ptr_d   = adr[34:35];
              rem_d   = rq;
              wr_d    = wrRq;
              cnt_d   = '0;
              state_d = S_ACKW;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_ACKW: begin
          if (cnt_q == ACK_LAST) begin
            ack_d = 1'b1;
            cnt_d = '0;
            if (rem_q == '0)  state_d = S_DONE;
            else if (wr_q)    state_d = S_WRW;
            else              state_d = S_RDW;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_RDW: begin
          if (cnt_q == RD_LAST) begin
            inv_d          = 1'b1;
            din_d          = mem[mem_idx];
            par_d          = ~^mem[mem_idx];
            rem_d[cur_pos] = 1'b0;
            ptr_d          = cur_pos + 2'd1;
            cnt_d          = '0;
            if (last_word) state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_WRW: begin
          if (outValidA) begin
            if (^{dOut, parOut}) mem_we = 1'b1;
            else                 err_d  = 1'b1;
            rem_d[cur_pos] = 1'b0;
            ptr_d          = cur_pos + 2'd1;
            if (last_word) state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      rem_q   <= '0;
      ptr_q   <= '0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      inv_q   <= 1'b0;
      din_q   <= '0;
      par_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      inv_q   <= inv_d;
      din_q   <= din_d;
      par_q   <= par_d;
      err_q   <= err_d;
    end
  end

  // Backing store is not reset. mem_we can only fire from WRW, which reset
  // leaves immediately, so an aborted transfer writes nothing further.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= dOut;
  end

  assign acknA       = ack_q;
  assign inValidA    = inv_q;
  assign dIn         = din_q;
  assign parIn       = par_q;
  assign error       = err_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mbus_memory_ctrl.sv
module tb_mbus_memory_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic        clk = 1'b0;
  logic        reset, memReset, startA, rdRq, wrRq;
  logic [0:3]  rq;
  logic [14:35] adr;
  logic        adrPar;
  logic [0:35] dOut;
  logic        parOut, outValidA;
  logic        acknA, inValidA;
  logic [0:35] dIn;
  logic        parIn, error, busy;
  logic [2:0]  dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [35:0] wv [4];   // per-transaction word list, in transfer order
  logic [3:0]  bad_par;  // per-word parity corruption for writes

  mbus_memory_ctrl dut (
    .clk(clk), .reset(reset), .memReset(memReset), .startA(startA),
    .rdRq(rdRq), .wrRq(wrRq), .rq(rq), .adr(adr), .adrPar(adrPar),
    .dOut(dOut), .parOut(parOut), .outValidA(outValidA),
    .acknA(acknA), .inValidA(inValidA), .dIn(dIn), .parIn(parIn),
    .error(error), .busy(busy), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at the negedge after accept
  task automatic issue(input bit rd, input bit wr, input logic [21:0] a,
                       input logic [3:0] m, input bit bad_ap);
    startA = 1'b1; rdRq = rd; wrRq = wr; rq = m;
    adr = a; adrPar = (~^a) ^ bad_ap;
    @(negedge clk);
    startA = 1'b0; rdRq = 1'b0; wrRq = 1'b0;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    while (!acknA && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 40) begin
      @(negedge clk);
      c++;
    end
    check(tag, 36'(busy), 36'd0);
  endtask

  task automatic read_txn(input string tag, input logic [21:0] a,
                          input logic [3:0] m, input int n);
    int cyc;
    issue(1'b1, 1'b0, a, m, 1'b0);
    wait_ack(cyc);
    check({tag, "_ack_lat"}, 36'(cyc), 36'd2);
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!inValidA && cyc < 20);
      check({tag, "_gap"}, 36'(cyc), 36'd3);
      check({tag, "_data"}, dIn, wv[i]);
      check({tag, "_par"}, 36'(parIn), 36'(~^wv[i]));
    end
    check({tag, "_done"}, 36'(dbg_state_o), 36'(ST_DONE));
    @(negedge clk);
    check({tag, "_idle"}, 36'(dbg_state_o), 36'(ST_IDLE));
  endtask

  task automatic write_txn(input string tag, input logic [21:0] a,
                           input logic [3:0] m, input int n);
    int cyc;
    issue(1'b0, 1'b1, a, m, 1'b0);
    wait_ack(cyc);
    check({tag, "_ack_lat"}, 36'(cyc), 36'd2);
    for (int i = 0; i < n; i++) begin
      outValidA = 1'b1;
      dOut      = wv[i];
      parOut    = (~^wv[i]) ^ bad_par[i];
      @(negedge clk);
      outValidA = 1'b0;
    end
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    int cyc, acks, invs;
    reset = 1'b1; memReset = 1'b0; startA = 1'b0; rdRq = 1'b0; wrRq = 1'b0;
    rq = '0; adr = '0; adrPar = 1'b1; dOut = '0; parOut = 1'b1;
    outValidA = 1'b0; bad_par = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 36'(acknA), 36'd0);
    check("rst_inv", 36'(inValidA), 36'd0);
    check("rst_din", dIn, 36'd0);
    check("rst_err", 36'(error), 36'd0);
    check("rst_busy", 36'(busy), 36'd0);
    reset = 1'b0;
    @(negedge clk);

    // read wrap
    wv[0] = 36'd1; wv[1] = 36'd2; wv[2] = 36'd3; wv[3] = 36'd4;
    write_txn("pre100", 22'h100, 4'b1111, 4);
    wv[0] = 36'd3; wv[1] = 36'd4; wv[2] = 36'd1; wv[3] = 36'd2;
    read_txn("rdwrap", 22'h102, 4'b1111, 4);

    // sparse write
    wv[0] = 36'hA0; wv[1] = 36'hA1; wv[2] = 36'hA2; wv[3] = 36'hA3;
    write_txn("pre200", 22'h200, 4'b1111, 4);
    wv[0] = 36'o777; wv[1] = 36'o123;
    write_txn("sparse", 22'h200, 4'b0101, 2);
    check("sparse_err", 36'(error), 36'd0);
    wv[0] = 36'hA0; wv[1] = 36'o777; wv[2] = 36'hA2; wv[3] = 36'o123;
    read_txn("sparse_rb", 22'h200, 4'b1111, 4);

    // write data parity error on the first word
    wv[0] = 36'o555; wv[1] = 36'o666; bad_par = 4'b0001;
    write_txn("wperr", 22'h200, 4'b0101, 2);
    bad_par = '0;
    check("wperr_err", 36'(error), 36'd1);
    wv[0] = 36'o777; wv[1] = 36'o666;
    read_txn("wperr_rb", 22'h201, 4'b0101, 2);
    check("wperr_sticky", 36'(error), 36'd1);
    memReset = 1'b1; @(negedge clk); memReset = 1'b0;
    check("memrst_err", 36'(error), 36'd0);

    // bad requests: rd==wr (both ways) and bad address parity
    for (int k = 0; k < 3; k++) begin
      if (k == 0)      issue(1'b1, 1'b1, 22'h100, 4'b1111, 1'b0);
      else if (k == 1) issue(1'b0, 1'b0, 22'h100, 4'b1111, 1'b0);
      else             issue(1'b1, 1'b0, 22'h100, 4'b1111, 1'b1);
      acks = 0;
      for (int j = 0; j < 4; j++) begin
        if (acknA) acks++;
        @(negedge clk);
      end
      check($sformatf("badrq%0d_ack", k), 36'(acks), 36'd0);
      check($sformatf("badrq%0d_err", k), 36'(error), 36'd1);
      check($sformatf("badrq%0d_busy", k), 36'(busy), 36'd0);
      memReset = 1'b1; @(negedge clk); memReset = 1'b0;
    end
    wv[0] = 36'd1;
    read_txn("legal_after", 22'h100, 4'b1000, 1);

    // startA held while busy and through DONE is ignored
    issue(1'b1, 1'b0, 22'h101, 4'b0100, 1'b0);
    startA = 1'b1; wrRq = 1'b1; adr = 22'h300; adrPar = ~^22'h300; rq = 4'b1111;
    acks = 0; invs = 0; cyc = 0;
    while (dbg_state_o != ST_DONE && cyc < 40) begin
      if (acknA) acks++;
      if (inValidA) begin
        invs++;
        check("busy_st_data", dIn, 36'd2);
      end
      @(negedge clk);
      cyc++;
    end
    if (inValidA) begin
      invs++;
      check("busy_st_data", dIn, 36'd2);
    end
    @(negedge clk);
    check("busy_st_idle", 36'(dbg_state_o), 36'(ST_IDLE));
    startA = 1'b0; wrRq = 1'b0;
    check("busy_st_acks", 36'(acks), 36'd1);
    check("busy_st_invs", 36'(invs), 36'd1);

    // rq=0000: acknowledge only
    issue(1'b1, 1'b0, 22'h100, 4'b0000, 1'b0);
    wait_ack(cyc);
    check("rq0_ack_lat", 36'(cyc), 36'd2);
    check("rq0_done", 36'(dbg_state_o), 36'(ST_DONE));
    @(negedge clk);
    check("rq0_idle", 36'(dbg_state_o), 36'(ST_IDLE));
    check("rq0_inv", 36'(inValidA), 36'd0);

    // abort: reset after the first of two words is written
    wv[0] = 36'h11; wv[1] = 36'h22;
    write_txn("pre400", 22'h400, 4'b1100, 2);
    issue(1'b1, 1'b1, 22'h400, 4'b1100, 1'b0);   // leaves error set
    issue(1'b0, 1'b1, 22'h400, 4'b1100, 1'b0);
    wait_ack(cyc);
    check("abort_ack_lat", 36'(cyc), 36'd2);
    outValidA = 1'b1; dOut = 36'h55; parOut = ~^36'h55;
    @(negedge clk);
    outValidA = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_ack", 36'(acknA), 36'd0);
    check("abort_inv", 36'(inValidA), 36'd0);
    check("abort_din", dIn, 36'd0);
    check("abort_par", 36'(parIn), 36'd0);
    check("abort_err", 36'(error), 36'd0);
    check("abort_busy", 36'(busy), 36'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wv[0] = 36'h55; wv[1] = 36'h22;
    read_txn("abort_rb", 22'h400, 4'b1100, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
